// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares one VGA adapter write port between N_REQ sprite
// datapaths. One burst of PIXELS plotted pixels is granted at a time.
//
// Ports:
//   clock, resetn              clock, asynchronous active-low reset
//   req[N_REQ]                 level burst requests, sampled only in IDLE
//   x_in/y_in/colour_in        packed per-requester pixel data (8/7/3 bits)
//   draw[N_REQ]                one-hot draw enable, PIXELS cycles per burst
//   finish[N_REQ]              one-cycle completion pulse after the burst
//   vga_x/vga_y/vga_colour     registered pixel to the VGA adapter
//   plot                       VGA write enable, lags draw by one cycle
//   busy                       high whenever the arbiter is not IDLE
//
// Build option: define VGA_ARB_FIXED_PRIORITY_EN for lowest-index-wins
// arbitration; round-robin is used otherwise.
module vga_plot_arbiter #(
    parameter int N_REQ  = 3,
    parameter int PIXELS = 32,
    parameter int CNT_W  = 5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*8-1:0] x_in,
    input  logic [N_REQ*7-1:0] y_in,
    input  logic [N_REQ*3-1:0] colour_in,
    output logic [N_REQ-1:0]   draw,
    output logic [N_REQ-1:0]   finish,
    output logic [7:0]         vga_x,
    output logic [6:0]         vga_y,
    output logic [2:0]         vga_colour,
    output logic               plot,
    output logic               busy
);

    localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAW,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   winner;
    logic               last_pix;
    logic [7:0]         sel_x;
    logic [6:0]         sel_y;
    logic [2:0]         sel_colour;

    assign last_pix = (cnt == CNT_W'(PIXELS - 1));

`ifdef VGA_ARB_FIXED_PRIORITY_EN

    // Descending scan: the lowest set index is written last and wins.
    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
    end

`else

    logic [IDX_W-1:0] last_grant;
    int               best_off;

    // Distance of requester i from last_grant going upward with wrap;
    // the previous winner itself is the farthest (offset N_REQ).
    function automatic int rr_off(input int i, input int last);
        return (i > last) ? (i - last) : (i + N_REQ - last);
    endfunction

    always_comb begin
        winner   = '0;
        best_off = N_REQ + 1;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && rr_off(i, int'(last_grant)) < best_off) begin
                winner   = IDX_W'(i);
                best_off = rr_off(i, int'(last_grant));
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_grant <= IDX_W'(N_REQ - 1);
        end else if (state == IDLE && |req) begin
            last_grant <= winner;
        end
    end

`endif

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_x      = x_in[8*i +: 8];
                sel_y      = y_in[7*i +: 7];
                sel_colour = colour_in[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        draw     = '0;
        finish   = '0;
        busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (|req) state_nx = GRANT;
            end
            GRANT: begin
                state_nx = DRAW;
            end
            DRAW: begin
                for (int i = 0; i < N_REQ; i++) begin
                    draw[i] = (grant_idx == IDX_W'(i));
                end
                if (last_pix) state_nx = DONE;
            end
            DONE: begin
                for (int i = 0; i < N_REQ; i++) begin
                    finish[i] = (grant_idx == IDX_W'(i));
                end
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grant_idx <= '0;
        end else if (state == IDLE && |req) begin
            grant_idx <= winner;
        end
    end

    // The counter holds at PIXELS-1 rather than wrapping when PIXELS
    // equals 2**CNT_W.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (state == GRANT) begin
            cnt <= '0;
        end else if (state == DRAW && !last_pix) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
        end else begin
            plot <= (state == DRAW);
            if (state == DRAW) begin
                vga_x      <= sel_x;
                vga_y      <= sel_y;
                vga_colour <= sel_colour;
            end
        end
    end

endmodule
